// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - pipeline-to-CP0 bus: register access, victim state, exception handshake
interface cp0_unit_if;
   logic [4:0]  A;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic        BD;
   logic [4:0]  ExcCode;
   logic [5:0]  HWInt;
   logic        ExlSet;
   logic        ExlClr;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] DOut;

   modport master (
      output A, DIn, WE, PC, BD, ExcCode, HWInt, ExlSet, ExlClr,
      input  IntReq, EPC, DOut
   );

   modport slave (
      input  A, DIn, WE, PC, BD, ExcCode, HWInt, ExlSet, ExlClr,
      output IntReq, EPC, DOut
   );
endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 SR/Cause/EPC/PRId register file and interrupt arbiter
// Optional Count/Compare timer source is built when CP0_TIMER_EN is defined.
module cp0_unit #(
   parameter logic [31:0] PRID_VALUE = 32'h0000_5A07
) (
   input  logic         clk,
   input  logic         reset,
   cp0_unit_if.slave    bus
);
   logic [5:0]  sr_im_q, sr_im_d;
   logic        sr_exl_q, sr_exl_d;
   logic        sr_ie_q, sr_ie_d;
   logic        cause_bd_q, cause_bd_d;
   logic [5:0]  cause_ip_q, cause_ip_d;
   logic [4:0]  cause_exc_q, cause_exc_d;
   logic [31:0] epc_q, epc_d;
   logic        ti;
   logic [5:0]  ip_live;
   logic        int_req;
   logic        wr_sr, wr_epc;
   logic [31:0] epc_victim;
   logic [31:0] dout;

`ifdef CP0_TIMER_EN
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;

   assign ti = ti_q;

   // Compare write beats a same-edge match so software can always acknowledge TI.
   always_comb begin
      count_d   = count_q + 32'd1;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (bus.WE && bus.A == 5'd9)
         count_d = bus.DIn;
      if (count_d == compare_q)
         ti_d = 1'b1;
      if (bus.WE && bus.A == 5'd11) begin
         compare_d = bus.DIn;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end
`else
   assign ti = 1'b0;
`endif

   assign ip_live    = bus.HWInt | {ti, 5'b0};
   assign int_req    = (|(ip_live & sr_im_q)) & sr_ie_q & ~sr_exl_q;
   // An mtc0 colliding with exception entry is flushed, so its SR/EPC write is dropped.
   assign wr_sr      = bus.WE && bus.A == 5'd12 && !bus.ExlSet;
   assign wr_epc     = bus.WE && bus.A == 5'd14 && !bus.ExlSet;
   assign epc_victim = bus.BD ? (bus.PC - 32'd4) : bus.PC;

   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_ip_d  = ip_live;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;
      if (wr_sr) begin
         sr_im_d  = bus.DIn[15:10];
         sr_exl_d = bus.DIn[1];
         sr_ie_d  = bus.DIn[0];
      end
      if (wr_epc)
         epc_d = {bus.DIn[31:2], 2'b00};
      if (bus.ExlSet) begin
         sr_exl_d    = 1'b1;
         cause_bd_d  = bus.BD;
         cause_exc_d = int_req ? 5'd0 : bus.ExcCode;
         epc_d       = {epc_victim[31:2], 2'b00};
      end else if (bus.ExlClr) begin
         sr_exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sr_im_q     <= '0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= '0;
         cause_exc_q <= '0;
         epc_q       <= '0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

   always_comb begin
      dout = '0;
      case (bus.A)
`ifdef CP0_TIMER_EN
         5'd9:  dout = count_q;
         5'd11: dout = compare_q;
`endif
         5'd12: dout = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
         5'd13: dout = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
         5'd14: dout = epc_q;
         5'd15: dout = PRID_VALUE;
         default: dout = '0;
      endcase
   end

   assign bus.IntReq = int_req;
   assign bus.EPC    = epc_q;
   assign bus.DOut   = dout;
endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - scoreboard bench for cp0_unit; timer vectors run when CP0_TIMER_EN is defined
module tb_cp0_unit;
   logic clk = 1'b0;
   logic reset;
   int   cyc_n = 0;
   int   applied = 0;
   int   miscompares = 0;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];

   cp0_unit_if bus ();

   cp0_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // kind 0 = DOut, 1 = IntReq, 2 = EPC; checked at the negedge of the cycle they were issued in
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
         exp_t e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.kind)
            0:       act = bus.DOut;
            1:       act = {31'b0, bus.IntReq};
            default: act = bus.EPC;
         endcase
         applied++;
         if (e.cyc != cyc_n || act !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc_n);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input int kind, input logic [31:0] v, input string name);
      exp_t e;
      e.cyc  = cyc_n;
      e.kind = kind;
      e.exp  = v;
      e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      reset = 1'b0;
      bus.A = 5'd0; bus.DIn = '0; bus.WE = 1'b0; bus.PC = '0; bus.BD = 1'b0;
      bus.ExcCode = '0; bus.HWInt = 6'h3F; bus.ExlSet = 1'b0; bus.ExlClr = 1'b0;
      cyc(); cyc();

      reset = 1'b1; bus.A = 5'd15;
      expect_v(0, 32'h0000_5A07, "prid");
      expect_v(1, 32'd0, "reset_intreq");
      expect_v(2, 32'd0, "reset_epc");
      cyc();
      bus.A = 5'd12; bus.HWInt = 6'd0;
      expect_v(0, 32'd0, "reset_sr");
      cyc();

      bus.WE = 1'b1; bus.DIn = 32'h0000_FC01;
      cyc();
      bus.WE = 1'b0; bus.HWInt = 6'b000100;
      expect_v(0, 32'h0000_FC01, "sr_readback");
      expect_v(1, 32'd1, "intreq_same_cycle");
      cyc();
      bus.A = 5'd13;
      expect_v(0, 32'h0000_1000, "cause_ip");
      cyc();

      bus.HWInt = 6'd0; bus.ExlSet = 1'b1; bus.PC = 32'h0000_3010; bus.BD = 1'b1; bus.ExcCode = 5'd12;
      expect_v(1, 32'd0, "no_irq_pending");
      cyc();
      bus.ExlSet = 1'b0; bus.BD = 1'b0; bus.ExcCode = 5'd0; bus.HWInt = 6'b000100;
      expect_v(2, 32'h0000_300C, "epc_bd");
      expect_v(0, 32'h8000_0030, "cause_bd_exc");
      expect_v(1, 32'd0, "intreq_masked_exl");
      cyc();
      bus.A = 5'd12;
      expect_v(0, 32'h0000_FC03, "sr_exl_set");
      cyc();

      bus.ExlSet = 1'b1; bus.WE = 1'b1; bus.A = 5'd14; bus.DIn = 32'hDEAD_BEEF; bus.PC = 32'h0000_3020;
      cyc();
      bus.ExlSet = 1'b0; bus.WE = 1'b0;
      expect_v(2, 32'h0000_3020, "epc_collision");
      expect_v(0, 32'h0000_3020, "epc_read");
      cyc();
      bus.ExlClr = 1'b1; bus.A = 5'd12;
      expect_v(0, 32'h0000_FC03, "exl_before_clr");
      cyc();
      bus.ExlClr = 1'b0;
      expect_v(0, 32'h0000_FC01, "exl_cleared");
      expect_v(1, 32'd1, "intreq_after_eret");
      cyc();

      bus.WE = 1'b1; bus.A = 5'd14; bus.DIn = 32'h0000_3007;
      cyc();
      bus.WE = 1'b0;
      expect_v(0, 32'h0000_3004, "epc_align_read");
      expect_v(2, 32'h0000_3004, "epc_align_port");
      cyc();
      bus.WE = 1'b1; bus.A = 5'd13; bus.DIn = 32'hFFFF_FFFF;
      expect_v(0, 32'h0000_1000, "cause_before_wr");
      cyc();
      bus.WE = 1'b0;
      expect_v(0, 32'h0000_1000, "cause_readonly");
      cyc();
      bus.WE = 1'b1; bus.A = 5'd3; bus.DIn = 32'h1234_5678;
      cyc();
      bus.WE = 1'b0;
      expect_v(0, 32'd0, "unlisted_reg");
      cyc();
`ifndef CP0_TIMER_EN
      bus.WE = 1'b1; bus.A = 5'd11; bus.DIn = 32'h55;
      cyc();
      bus.WE = 1'b0;
      expect_v(0, 32'd0, "compare_absent");
      cyc();
      bus.A = 5'd9;
      expect_v(0, 32'd0, "count_absent");
      cyc();
`endif

      reset = 1'b0; bus.ExlSet = 1'b1; bus.PC = 32'h0000_4000; bus.WE = 1'b1; bus.A = 5'd12; bus.DIn = 32'h0000_FC01;
      cyc();
      reset = 1'b1; bus.ExlSet = 1'b0; bus.WE = 1'b0;
      expect_v(0, 32'd0, "midreset_sr");
      expect_v(2, 32'd0, "midreset_epc");
      expect_v(1, 32'd0, "midreset_intreq");
      cyc();

`ifdef CP0_TIMER_EN
      bus.HWInt = 6'd0;
      bus.WE = 1'b1; bus.A = 5'd12; bus.DIn = 32'h0000_8001;
      cyc();
      bus.A = 5'd11; bus.DIn = 32'd20;
      cyc();
      bus.A = 5'd9; bus.DIn = 32'd10;
      cyc();
      bus.WE = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         expect_v(0, 32'd10 + k, $sformatf("count_%0d", k));
         expect_v(1, (k == 10) ? 32'd1 : 32'd0, $sformatf("timer_irq_%0d", k));
         if (k == 10) begin
            bus.WE = 1'b1; bus.A = 5'd11; bus.DIn = 32'd100;
         end
         cyc();
      end
      bus.WE = 1'b0;
      expect_v(1, 32'd0, "ti_cleared");
      cyc();
`endif

      cyc(); cyc();
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         miscompares += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
